// File: rtl/conv2_maxpool.sv
// conv2_maxpool: 2x2 stride-2 signed max-pool of a 3x8x8 conv2 map into a 3x4x4 pool map.
// Optional POOL_RELU_EN fuses a ReLU into the write stage. Revision 1.0.
`default_nettype none

module conv2_maxpool #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    output logic [5:0]               o_rd_addr,
    output logic [1:0]               o_rd_count,
    output logic                     o_rd_en,
    input  logic signed [DATA_W-1:0] i_rd_data,
    output logic [3:0]               o_wr_addr,
    output logic [1:0]               o_wr_count,
    output logic                     o_wr_en,
    output logic signed [DATA_W-1:0] o_wr_data,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0] r_c;
    logic [1:0] r_py;
    logic [1:0] r_px;
    logic [1:0] r_p;
    logic       w_last_rd;
    logic       w_rd_en;
    logic       w_busy;
    logic       w_done;

    // Read-side tags delayed one cycle so they line up with returning data
    logic       r_vld;
    logic [1:0] r_ph;
    logic [3:0] r_win;
    logic [1:0] r_wc;

    logic signed [DATA_W-1:0] r_max;
    logic signed [DATA_W-1:0] w_final;
    logic signed [DATA_W-1:0] w_wr_val;

    logic                     r_wr_en;
    logic [3:0]               r_wr_addr;
    logic [1:0]               r_wr_count;
    logic signed [DATA_W-1:0] r_wr_data;

    assign w_last_rd = (r_c == 2'd2) && (r_py == 2'd3) && (r_px == 2'd3) && (r_p == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (w_last_rd) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_wr_en) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (i_start) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read walk: phase fastest, then px, py, channel; all wrap back to zero after the pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c  <= 2'd0;
            r_py <= 2'd0;
            r_px <= 2'd0;
            r_p  <= 2'd0;
        end else if (r_state == S_RUN) begin
            r_p <= r_p + 2'd1;
            if (r_p == 2'd3) begin
                r_px <= r_px + 2'd1;
                if (r_px == 2'd3) begin
                    r_py <= r_py + 2'd1;
                    if (r_py == 2'd3) begin
                        r_c <= (r_c == 2'd2) ? 2'd0 : r_c + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_ph  <= 2'd0;
            r_win <= 4'd0;
            r_wc  <= 2'd0;
        end else begin
            r_vld <= w_rd_en;
            r_ph  <= r_p;
            r_win <= {r_py, r_px};
            r_wc  <= r_c;
        end
    end

    assign w_final = (i_rd_data > r_max) ? i_rd_data : r_max;

`ifdef POOL_RELU_EN
    assign w_wr_val = w_final[DATA_W-1] ? '0 : w_final;
`else
    assign w_wr_val = w_final;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 4'd0;
            r_wr_count <= 2'd0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= r_vld && (r_ph == 2'd3);
            if (r_vld) begin
                if ((r_ph == 2'd0) || (i_rd_data > r_max)) r_max <= i_rd_data;
                if (r_ph == 2'd3) begin
                    r_wr_data  <= w_wr_val;
                    r_wr_addr  <= r_win;
                    r_wr_count <= r_wc;
                end
            end
        end
    end

    assign o_rd_addr  = {r_py, r_p[1], r_px, r_p[0]};
    assign o_rd_count = r_c;
    assign o_rd_en    = w_rd_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_count = r_wr_count;
    assign o_wr_en    = r_wr_en;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = w_busy;
    assign o_done     = w_done;

endmodule

`default_nettype wire

// File: tb/tb_conv2_maxpool.sv
// tb_conv2_maxpool: directed self-checking bench for conv2_maxpool with a registered-read memory model.
// Revision 1.0.
`default_nettype none

module tb_conv2_maxpool;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [5:0]         rd_addr;
    logic [1:0]         rd_count;
    logic               rd_en;
    logic signed [15:0] rd_data;
    logic [3:0]         wr_addr;
    logic [1:0]         wr_count;
    logic               wr_en;
    logic signed [15:0] wr_data;
    logic               busy;
    logic               done;

    logic signed [15:0] mem [0:2][0:63];
    logic signed [15:0] res [0:2][0:15];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int nwr, wcyc_bad, busy_first, busy_last, busy_cnt, rd_cnt, rd_last, done_k;

`ifdef POOL_RELU_EN
    localparam logic signed [15:0] EXP_NEG  = 16'sd0;
    localparam logic signed [15:0] EXP_NEG1 = 16'sd0;
`else
    localparam logic signed [15:0] EXP_NEG  = -16'sd2;
    localparam logic signed [15:0] EXP_NEG1 = -16'sd1;
`endif

    conv2_maxpool #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .o_rd_addr  (rd_addr),
        .o_rd_count (rd_count),
        .o_rd_en    (rd_en),
        .i_rd_data  (rd_data),
        .o_wr_addr  (wr_addr),
        .o_wr_count (wr_count),
        .o_wr_en    (wr_en),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_count][rd_addr];
    end

    task automatic fill_ramp();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 64; a++)
                mem[c][a] = 16'(64 * c + a);
    endtask

    // Call at a negedge: start is sampled by the next posedge, which is cycle 0
    task automatic begin_pass();
        start      = 1'b1;
        base       = cyc;
        nwr        = 0;
        wcyc_bad   = 0;
        busy_first = -1;
        busy_last  = -1;
        busy_cnt   = 0;
        rd_cnt     = 0;
        rd_last    = -1;
        done_k     = -1;
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 16; a++)
                res[c][a] = 'x;
    endtask

    task automatic run_pass(input int extra);
        int k;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            k = cyc - base;
            if (k == extra) start = 1'b1;
            if (busy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
                busy_cnt++;
            end
            if (rd_en) begin
                rd_cnt++;
                rd_last = k;
            end
            if (wr_en) begin
                if (k != 6 + 4 * nwr) wcyc_bad++;
                if (wr_count < 2'd3) res[wr_count][wr_addr] = wr_data;
                else wcyc_bad++;
                nwr++;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_addr, rd_count, rd_en, wr_addr, wr_count, wr_en, wr_data, busy, done} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rd_addr, rd_count, rd_en, wr_addr, wr_count, wr_en, wr_data, busy, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        logic signed [15:0] exp_v;
        fill_ramp();
        begin_pass();
        run_pass(-1);
        checks++;
        if (nwr != 48) begin errors++; $display("FAIL ramp_nwr: got %0d expected 48", nwr); end
        checks++;
        if (done_k != 195) begin errors++; $display("FAIL ramp_done_cycle: got %0d expected 195", done_k); end
        checks++;
        if (wcyc_bad != 0) begin errors++; $display("FAIL ramp_wr_cycles: got %0d bad expected 0", wcyc_bad); end
        checks++;
        if (busy_first != 1 || busy_last != 194 || busy_cnt != 194) begin
            errors++;
            $display("FAIL ramp_busy: got first %0d last %0d cnt %0d expected 1 194 194", busy_first, busy_last, busy_cnt);
        end
        checks++;
        if (rd_cnt != 192 || rd_last != 192) begin
            errors++;
            $display("FAIL ramp_rd: got cnt %0d last %0d expected 192 192", rd_cnt, rd_last);
        end
        checks++;
        if (res[0][0] !== 16'sd9) begin errors++; $display("FAIL ramp_c0_a0: got %0d expected 9", res[0][0]); end
        checks++;
        if (res[1][5] !== 16'sd91) begin errors++; $display("FAIL ramp_c1_a5: got %0d expected 91", res[1][5]); end
        checks++;
        if (res[2][15] !== 16'sd191) begin errors++; $display("FAIL ramp_c2_a15: got %0d expected 191", res[2][15]); end
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 16; a++) begin
                exp_v = 16'(64 * c + 16 * (a / 4) + 2 * (a % 4) + 9);
                checks++;
                if (res[c][a] !== exp_v) begin
                    errors++;
                    $display("FAIL ramp_all c%0d a%0d: got %0d expected %0d", c, a, res[c][a], exp_v);
                end
            end
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL ramp_done_sticky: got done %b busy %b rd_en %b wr_en %b expected 1 0 0 0", done, busy, rd_en, wr_en);
        end
    endtask

    task automatic test_values();
        int pofs [4] = '{0, 1, 8, 9};
        fill_ramp();
        mem[0][0] = -16'sd5;  mem[0][1] = -16'sd2;  mem[0][8] = -16'sd9;  mem[0][9] = -16'sd3;
        mem[0][2] = 16'sd7;   mem[0][3] = 16'sd7;   mem[0][10] = 16'sd7;  mem[0][11] = 16'sd7;
        for (int w = 0; w < 4; w++) mem[1][2 * w + pofs[w]] = 16'sd500;
        mem[2][0] = -16'sd7;  mem[2][1] = 16'sd3;   mem[2][8] = -16'sd8;  mem[2][9] = 16'sd2;
        mem[2][2] = -16'sd30000; mem[2][3] = -16'sd20000; mem[2][10] = -16'sd1; mem[2][11] = -16'sd25000;
        begin_pass();
        run_pass(-1);
        checks++;
        if (res[0][0] !== EXP_NEG) begin errors++; $display("FAIL neg_window: got %0d expected %0d", res[0][0], EXP_NEG); end
        checks++;
        if (res[0][1] !== 16'sd7) begin errors++; $display("FAIL tie_window: got %0d expected 7", res[0][1]); end
        checks++;
        if (res[0][2] !== 16'sd13) begin errors++; $display("FAIL untouched_window: got %0d expected 13", res[0][2]); end
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (res[1][w] !== 16'sd500) begin
                errors++;
                $display("FAIL max_phase%0d: got %0d expected 500", w, res[1][w]);
            end
        end
        checks++;
        if (res[2][0] !== 16'sd3) begin errors++; $display("FAIL signed_mix: got %0d expected 3", res[2][0]); end
        checks++;
        if (res[2][1] !== EXP_NEG1) begin errors++; $display("FAIL all_negative: got %0d expected %0d", res[2][1], EXP_NEG1); end
        checks++;
        if (nwr != 48 || done_k != 195) begin
            errors++;
            $display("FAIL values_pass: got nwr %0d done %0d expected 48 195", nwr, done_k);
        end
    endtask

    task automatic test_start_ignored();
        fill_ramp();
        begin_pass();
        run_pass(50);
        checks++;
        if (nwr != 48) begin errors++; $display("FAIL busy_start_nwr: got %0d expected 48", nwr); end
        checks++;
        if (done_k != 195) begin errors++; $display("FAIL busy_start_done: got %0d expected 195", done_k); end
        checks++;
        if (wcyc_bad != 0 || rd_cnt != 192) begin
            errors++;
            $display("FAIL busy_start_timing: got bad %0d rd %0d expected 0 192", wcyc_bad, rd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_ramp();
        begin_pass();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc - base == 100) break;
        end
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if ({rd_addr, rd_count, rd_en, wr_addr, wr_count, wr_en, wr_data, busy, done} !== 34'd0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_reset_outputs: got %0d nonzero samples expected 0", bad); end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ({rd_addr, rd_count, rd_en, wr_addr, wr_count, wr_en, wr_data, busy, done} !== 34'd0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d nonzero samples expected 0", bad); end
        begin_pass();
        run_pass(-1);
        checks++;
        if (nwr != 48 || done_k != 195 || wcyc_bad != 0) begin
            errors++;
            $display("FAIL post_reset_pass: got nwr %0d done %0d bad %0d expected 48 195 0", nwr, done_k, wcyc_bad);
        end
        checks++;
        if (res[1][5] !== 16'sd91) begin errors++; $display("FAIL post_reset_c1_a5: got %0d expected 91", res[1][5]); end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] exp_v;
        int errs;
        fill_ramp();
        begin_pass();
        run_pass(-1);
        checks++;
        if (done_k != 195) begin errors++; $display("FAIL b2b_first_done: got %0d expected 195", done_k); end
        begin_pass();
        run_pass(-1);
        checks++;
        if (done_k != 195) begin errors++; $display("FAIL b2b_second_done: got %0d expected 195", done_k); end
        checks++;
        if (nwr != 48 || wcyc_bad != 0 || busy_first != 1 || busy_last != 194) begin
            errors++;
            $display("FAIL b2b_timing: got nwr %0d bad %0d busy %0d..%0d expected 48 0 1..194", nwr, wcyc_bad, busy_first, busy_last);
        end
        errs = 0;
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 16; a++) begin
                exp_v = 16'(64 * c + 16 * (a / 4) + 2 * (a % 4) + 9);
                if (res[c][a] !== exp_v) errs++;
            end
        checks++;
        if (errs != 0) begin errors++; $display("FAIL b2b_results: got %0d wrong values expected 0", errs); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_values();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
